// File: rtl/sram_axi_responder.sv
// AXI4 INCR-burst slave (1-16 x 32-bit beats) driving a single-port synchronous SRAM, one transaction at a time.
// Each beat takes 2 cycles. RVALID/BVALID are held until accepted, and no new address is taken until the response completes.
module sram_axi_responder #(
    parameter int ID_W    = 8,
    parameter int DEPTH_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ID_W-1:0]    ARID,
    input  logic [31:0]        ARADDR,
    input  logic [3:0]         ARLEN,
    input  logic               ARVALID,
    output logic               ARREADY,
    output logic [ID_W-1:0]    RID,
    output logic [31:0]        RDATA,
    output logic [1:0]         RRESP,
    output logic               RLAST,
    output logic               RVALID,
    input  logic               RREADY,
    input  logic [ID_W-1:0]    AWID,
    input  logic [31:0]        AWADDR,
    input  logic [3:0]         AWLEN,
    input  logic               AWVALID,
    output logic               AWREADY,
    input  logic [31:0]        WDATA,
    input  logic [3:0]         WSTRB,
    input  logic               WLAST,
    input  logic               WVALID,
    output logic               WREADY,
    output logic [ID_W-1:0]    BID,
    output logic [1:0]         BRESP,
    output logic               BVALID,
    input  logic               BREADY,
    output logic               SRAM_CEB,
    output logic [3:0]         SRAM_WEB,
    output logic               SRAM_OE,
    output logic [DEPTH_W-1:0] SRAM_A,
    output logic [31:0]        SRAM_DI,
    input  logic [31:0]        SRAM_DO
);

    typedef enum logic [2:0] {IDLE, R_ACC, R_DATA, W_DATA, W_ACC, B_RESP} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [DEPTH_W-1:0] addr_q, addr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               err_addr_q, err_addr_d;
    logic               err_last_q, err_last_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               fresh_q;
    logic               last_beat;
    logic [31:0]        rd_word;
    logic               unused_addr_lsbs;

    assign last_beat        = (cnt_q == 4'd0);
    assign rd_word          = err_addr_q ? 32'd0 : SRAM_DO;
    assign unused_addr_lsbs = ^{ARADDR[1:0], AWADDR[1:0]};

    assign SRAM_A  = addr_q;
    assign SRAM_DI = wdata_q;
    assign RID     = id_q;
    assign BID     = id_q;

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        err_addr_d = err_addr_q;
        err_last_d = err_last_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        ARREADY    = 1'b0;
        AWREADY    = 1'b0;
        RVALID     = 1'b0;
        RLAST      = 1'b0;
        RRESP      = 2'b00;
        RDATA      = rdata_q;
        WREADY     = 1'b0;
        BVALID     = 1'b0;
        BRESP      = 2'b00;
        SRAM_CEB   = 1'b1;
        SRAM_WEB   = 4'hF;
        SRAM_OE    = 1'b0;
        case (state_q)
            IDLE: begin
                // Read wins a tie; AWREADY is the one output that looks at an input.
                ARREADY = 1'b1;
                AWREADY = !ARVALID;
                if (ARVALID) begin
                    id_d       = ARID;
                    addr_d     = ARADDR[DEPTH_W+1:2];
                    cnt_d      = ARLEN;
                    err_addr_d = |ARADDR[31:DEPTH_W+2];
                    state_d    = R_ACC;
                end else if (AWVALID) begin
                    id_d       = AWID;
                    addr_d     = AWADDR[DEPTH_W+1:2];
                    cnt_d      = AWLEN;
                    err_addr_d = |AWADDR[31:DEPTH_W+2];
                    err_last_d = 1'b0;
                    state_d    = W_DATA;
                end
            end
            R_ACC: begin
                if (!err_addr_q) begin
                    SRAM_CEB = 1'b0;
                    SRAM_OE  = 1'b1;
                end
                state_d = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                RLAST  = last_beat;
                RRESP  = err_addr_q ? 2'b10 : 2'b00;
                // SRAM output is live only on the first data cycle; hold a copy for stalls.
                if (fresh_q) begin
                    RDATA   = rd_word;
                    rdata_d = rd_word;
                end
                if (RREADY) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                        addr_d  = addr_q + DEPTH_W'(1);
                        state_d = R_ACC;
                    end
                end
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID) begin
                    wdata_d = WDATA;
                    wstrb_d = WSTRB;
                    if (WLAST != last_beat) err_last_d = 1'b1;
                    state_d = W_ACC;
                end
            end
            W_ACC: begin
                if (!err_addr_q) begin
                    SRAM_CEB = 1'b0;
                    SRAM_WEB = ~wstrb_q;
                end
                if (last_beat) begin
                    state_d = B_RESP;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    addr_d  = addr_q + DEPTH_W'(1);
                    state_d = W_DATA;
                end
            end
            B_RESP: begin
                BVALID = 1'b1;
                BRESP  = (err_addr_q || err_last_q) ? 2'b10 : 2'b00;
                if (BREADY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            err_addr_q <= 1'b0;
            err_last_q <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            fresh_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            err_addr_q <= err_addr_d;
            err_last_q <= err_last_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            fresh_q    <= (state_q == R_ACC);
        end
    end

endmodule

// File: tb/tb_sram_axi_responder.sv
// Bench for sram_axi_responder: SRAM macro model, AXI master tasks and a word-array reference memory
// updated per transaction.
module tb_sram_axi_responder;
    localparam int ID_W    = 8;
    localparam int DEPTH_W = 14;
    localparam int WORDS   = 1 << DEPTH_W;

    logic clk = 1'b0;
    logic rst;
    logic [ID_W-1:0] ARID, RID, AWID, BID;
    logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
    logic [3:0]  ARLEN, AWLEN, WSTRB;
    logic ARVALID, ARREADY, RVALID, RREADY, RLAST;
    logic [1:0] RRESP, BRESP;
    logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic SRAM_CEB, SRAM_OE;
    logic [3:0] SRAM_WEB;
    logic [DEPTH_W-1:0] SRAM_A;
    logic [31:0] SRAM_DI, SRAM_DO;

    always #5 clk = ~clk;

    sram_axi_responder #(.ID_W(ID_W), .DEPTH_W(DEPTH_W)) dut (
        .clk(clk), .rst(rst),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .SRAM_CEB(SRAM_CEB), .SRAM_WEB(SRAM_WEB), .SRAM_OE(SRAM_OE), .SRAM_A(SRAM_A),
        .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
    );

    // SRAM macro model with a side port for preloading contents.
    logic [31:0] mem [0:WORDS-1];
    logic pl_en;
    logic [DEPTH_W-1:0] pl_addr;
    logic [31:0] pl_dat;
    int ceb_cnt = 0;

    always @(posedge clk) begin : sram_model
        logic [31:0] w;
        if (pl_en) mem[pl_addr] <= pl_dat;
        if (!SRAM_CEB) begin
            ceb_cnt <= ceb_cnt + 1;
            if (SRAM_WEB == 4'hF) begin
                SRAM_DO <= mem[SRAM_A];
            end else begin
                w = mem[SRAM_A];
                for (int b = 0; b < 4; b++)
                    if (!SRAM_WEB[b]) w[8*b +: 8] = SRAM_DI[8*b +: 8];
                mem[SRAM_A] <= w;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [0:WORDS-1];
    logic [31:0] wdat [16];
    logic [3:0]  wstb [16];
    logic [15:0] wlast_m;

    logic [31:0] rq_data [$];
    logic [1:0]  rq_resp [$];
    logic        rq_last [$];
    logic [7:0]  rq_id   [$];
    int          rq_lat  [$];
    int          stall_bad;

    // Reference model: a flat word array, updated once per transaction.
    function automatic logic addr_err(input logic [31:0] a);
        return (a >> (DEPTH_W + 2)) != 0;
    endfunction

    function automatic int word_of(input logic [31:0] a, input int i);
        return (int'(a >> 2) + i) % WORDS;
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] a, input int len);
        logic mism = 1'b0;
        for (int i = 0; i <= len; i++)
            if (wlast_m[i] != (i == len)) mism = 1'b1;
        if (!addr_err(a)) begin
            for (int i = 0; i <= len; i++)
                for (int b = 0; b < 4; b++)
                    if (wstb[i][b]) ref_mem[word_of(a, i)][8*b +: 8] = wdat[i][8*b +: 8];
        end
        return (addr_err(a) || mism) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int i);
        return addr_err(a) ? 32'd0 : ref_mem[word_of(a, i)];
    endfunction

    task automatic preload(input int word, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = word[DEPTH_W-1:0]; pl_dat = d;
        ref_mem[word] = d;
        @(posedge clk); #1 pl_en = 1'b0;
    endtask

    task automatic send_aw(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len);
        int g = 0;
        @(negedge clk);
        AWID = id; AWADDR = a; AWLEN = len; AWVALID = 1'b1;
        while (!AWREADY && g < 50) begin @(negedge clk); g++; end
        if (!AWREADY) begin
            checks++; errors++;
            $display("FAIL aw_handshake: AWREADY=%0b, required 1 within 50 cycles", AWREADY);
        end
        @(posedge clk); #1 AWVALID = 1'b0;
    endtask

    task automatic send_w_b(input int len, output logic [1:0] br, output logic [7:0] bi, output int bl);
        int k;
        for (int i = 0; i <= len; i++) begin
            int g = 0;
            @(negedge clk);
            WVALID = 1'b1; WDATA = wdat[i]; WSTRB = wstb[i]; WLAST = wlast_m[i];
            while (!WREADY && g < 50) begin @(negedge clk); g++; end
            if (!WREADY) begin
                checks++; errors++;
                $display("FAIL w_handshake beat %0d: WREADY=%0b, required 1", i, WREADY);
            end
            @(posedge clk); #1 WVALID = 1'b0; WLAST = 1'b0;
        end
        BREADY = 1'b1;
        k = 0;
        br = 2'bxx; bi = 'x; bl = -1;
        while (!BVALID && k < 50) begin @(negedge clk); k++; end
        if (BVALID) begin
            br = BRESP; bi = BID; bl = k;
        end else begin
            checks++; errors++;
            $display("FAIL b_timeout: BVALID=%0b, required 1 within 50 cycles", BVALID);
        end
        @(posedge clk); #1 BREADY = 1'b0;
    endtask

    // mode 0: RREADY held high, 1: two high/two low pattern, 2: random
    task automatic do_read(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len, input int mode);
        int g = 0;
        int k = 0;
        int beats = 0;
        logic have_stall = 1'b0;
        logic [31:0] stall_dat = '0;
        rq_data.delete(); rq_resp.delete(); rq_last.delete(); rq_id.delete(); rq_lat.delete();
        stall_bad = 0;
        @(negedge clk);
        ARID = id; ARADDR = a; ARLEN = len; ARVALID = 1'b1;
        while (!ARREADY && g < 50) begin @(negedge clk); g++; end
        if (!ARREADY) begin
            checks++; errors++;
            $display("FAIL ar_handshake: ARREADY=%0b, required 1 within 50 cycles", ARREADY);
        end
        @(posedge clk); #1 ARVALID = 1'b0;
        while (beats <= int'(len) && k < 200) begin
            @(negedge clk); k++;
            case (mode)
                0:       RREADY = 1'b1;
                1:       RREADY = ((k / 2) % 2) == 1;
                default: RREADY = 1'($urandom_range(0, 1));
            endcase
            if (RVALID) begin
                if (have_stall && RDATA !== stall_dat) stall_bad++;
                if (RREADY) begin
                    rq_data.push_back(RDATA); rq_resp.push_back(RRESP);
                    rq_last.push_back(RLAST); rq_id.push_back(RID); rq_lat.push_back(k);
                    beats++;
                    have_stall = 1'b0;
                end else begin
                    have_stall = 1'b1;
                    stall_dat = RDATA;
                end
            end
        end
        if (beats <= int'(len)) begin
            checks++; errors++;
            $display("FAIL r_timeout: got %0d beats, required %0d", beats, int'(len) + 1);
        end
        @(posedge clk); #1 RREADY = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        for (int w = 0; w < 'h90; w++) preload(w, $urandom);
        for (int w = WORDS - 16; w < WORDS; w++) preload(w, $urandom);
        preload('h40, 32'hDEADBEEF);
        preload('h80, 32'hAABBCCDD);
        @(negedge clk);
        checks++;
        if (ARREADY !== 1'b1 || AWREADY !== 1'b1) begin
            errors++; $display("FAIL reset_ready: ARREADY=%0b AWREADY=%0b, required 1 1", ARREADY, AWREADY);
        end
        checks++;
        if (RVALID !== 1'b0 || BVALID !== 1'b0 || WREADY !== 1'b0) begin
            errors++; $display("FAIL reset_valids: RVALID=%0b BVALID=%0b WREADY=%0b, required 0 0 0", RVALID, BVALID, WREADY);
        end
        checks++;
        if (SRAM_CEB !== 1'b1 || SRAM_WEB !== 4'hF || SRAM_OE !== 1'b0) begin
            errors++; $display("FAIL reset_sram: CEB=%0b WEB=%h OE=%0b, required 1 f 0", SRAM_CEB, SRAM_WEB, SRAM_OE);
        end
        checks++;
        if (RDATA !== 32'd0 || RRESP !== 2'b00 || BRESP !== 2'b00 || RLAST !== 1'b0) begin
            errors++; $display("FAIL reset_resp: RDATA=%h RRESP=%0d BRESP=%0d RLAST=%0b, required 0 0 0 0", RDATA, RRESP, BRESP, RLAST);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        do_read(8'd5, 32'h100, 4'd0, 0);
        checks++;
        if (rq_data.size() != 1) begin
            errors++; $display("FAIL single_read_beats: got %0d, required 1", rq_data.size());
        end else begin
            checks++;
            if (rq_data[0] !== 32'hDEADBEEF || rq_resp[0] !== 2'b00 || rq_last[0] !== 1'b1 || rq_id[0] !== 8'd5) begin
                errors++; $display("FAIL single_read: data=%h resp=%0d last=%0b id=%0d, required deadbeef 0 1 5",
                                   rq_data[0], rq_resp[0], rq_last[0], rq_id[0]);
            end
            checks++;
            if (rq_lat[0] !== 2) begin
                errors++; $display("FAIL single_read_latency: got %0d cycles, required 2", rq_lat[0]);
            end
        end
    endtask

    task automatic test_strobed_write();
        logic [1:0] br; logic [7:0] bi; int bl; logic [1:0] exp_b;
        wdat[0] = 32'h11223344; wstb[0] = 4'b0101; wlast_m = 16'h0001;
        exp_b = model_write(32'h200, 0);
        send_aw(8'h3C, 32'h200, 4'd0);
        send_w_b(0, br, bi, bl);
        checks++;
        if (br !== exp_b || bi !== 8'h3C || bl !== 2) begin
            errors++; $display("FAIL strobe_bresp: bresp=%0d bid=%h lat=%0d, required %0d 3c 2", br, bi, bl, exp_b);
        end
        do_read(8'h3D, 32'h200, 4'd0, 0);
        checks++;
        if (rq_data.size() != 1 || rq_data[0] !== 32'hAA22CC44) begin
            errors++; $display("FAIL strobe_readback: got %h, required aa22cc44", rq_data.size() ? rq_data[0] : 32'hx);
        end
    endtask

    task automatic test_burst_stall();
        logic [31:0] a;
        a = 32'($urandom_range(0, 100)) << 2;
        do_read(8'h11, a, 4'd3, 1);
        checks++;
        if (rq_data.size() != 4) begin
            errors++; $display("FAIL burst_beats: got %0d, required 4", rq_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rq_data[i] !== model_read(a, i) || rq_last[i] !== (i == 3)) begin
                    errors++; $display("FAIL burst_beat %0d: data=%h last=%0b, required %h %0b",
                                       i, rq_data[i], rq_last[i], model_read(a, i), i == 3);
                end
            end
        end
        checks++;
        if (stall_bad !== 0) begin
            errors++; $display("FAIL burst_stall_hold: %0d stalled cycles changed RDATA, required 0", stall_bad);
        end
    endtask

    task automatic test_wrap_error();
        logic [1:0] br, exp_b; logic [7:0] bi; int bl; int c0;
        wdat[0] = $urandom; wdat[1] = $urandom; wstb[0] = 4'hF; wstb[1] = 4'hF; wlast_m = 16'h0002;
        exp_b = model_write(32'hFFFC, 1);
        send_aw(8'h21, 32'hFFFC, 4'd1);
        send_w_b(1, br, bi, bl);
        checks++;
        if (br !== exp_b) begin
            errors++; $display("FAIL wrap_bresp: got %0d, required %0d", br, exp_b);
        end
        do_read(8'h22, 32'hFFFC, 4'd1, 0);
        checks++;
        if (rq_data.size() != 2 || rq_data[0] !== wdat[0] || rq_data[1] !== wdat[1]) begin
            errors++; $display("FAIL wrap_readback: got %0d beats, required words 3fff=%h 0=%h", rq_data.size(), wdat[0], wdat[1]);
        end
        for (int i = 0; i < 3; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        wlast_m = 16'h0004;
        exp_b = model_write(32'h0001_0000, 2);
        c0 = ceb_cnt;
        send_aw(8'h23, 32'h0001_0000, 4'd2);
        send_w_b(2, br, bi, bl);
        checks++;
        if (br !== 2'b10 || br !== exp_b || ceb_cnt != c0) begin
            errors++; $display("FAIL err_write: bresp=%0d ceb_pulses=%0d, required 2 0", br, ceb_cnt - c0);
        end
        c0 = ceb_cnt;
        do_read(8'h24, 32'h8000_0040, 4'd2, 0);
        checks++;
        if (rq_data.size() != 3 || ceb_cnt != c0) begin
            errors++; $display("FAIL err_read: beats=%0d ceb_pulses=%0d, required 3 0", rq_data.size(), ceb_cnt - c0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rq_resp[i] !== 2'b10 || rq_data[i] !== 32'd0 || rq_last[i] !== (i == 2)) begin
                    errors++; $display("FAIL err_read_beat %0d: resp=%0d data=%h last=%0b, required 2 0 %0b",
                                       i, rq_resp[i], rq_data[i], rq_last[i], i == 2);
                end
            end
        end
    endtask

    task automatic test_priority();
        int aw_seen = 0;
        int beats = 0;
        int k = 0;
        logic [1:0] br, exp_b; logic [7:0] bi; int bl;
        @(negedge clk);
        ARID = 8'h07; ARADDR = 32'h40; ARLEN = 4'd1; ARVALID = 1'b1;
        AWID = 8'h09; AWADDR = 32'h20; AWLEN = 4'd0; AWVALID = 1'b1;
        #1;
        checks++;
        if (ARREADY !== 1'b1 || AWREADY !== 1'b0) begin
            errors++; $display("FAIL prio_idle: ARREADY=%0b AWREADY=%0b, required 1 0", ARREADY, AWREADY);
        end
        @(posedge clk); #1 ARVALID = 1'b0;
        RREADY = 1'b1;
        while (beats < 2 && k < 50) begin
            @(negedge clk); k++;
            if (AWREADY) aw_seen++;
            if (RVALID) beats++;
        end
        checks++;
        if (aw_seen != 0 || beats != 2) begin
            errors++; $display("FAIL prio_aw_blocked: AWREADY high %0d cycles over %0d beats, required 0 over 2", aw_seen, beats);
        end
        @(posedge clk); #1 RREADY = 1'b0;
        @(negedge clk);
        checks++;
        if (AWREADY !== 1'b1) begin
            errors++; $display("FAIL prio_aw_after: AWREADY=%0b, required 1", AWREADY);
        end
        @(posedge clk); #1 AWVALID = 1'b0;
        wdat[0] = $urandom; wstb[0] = 4'($urandom_range(1, 15)); wlast_m = 16'h0001;
        exp_b = model_write(32'h20, 0);
        send_w_b(0, br, bi, bl);
        checks++;
        if (br !== exp_b || bi !== 8'h09) begin
            errors++; $display("FAIL prio_write: bresp=%0d bid=%h, required %0d 09", br, bi, exp_b);
        end
    endtask

    task automatic test_early_wlast();
        logic [1:0] br, exp_b; logic [7:0] bi; int bl; int c0;
        logic [31:0] a;
        a = 32'($urandom_range(0, 120)) << 2;
        for (int i = 0; i < 3; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom_range(1, 15)); end
        wlast_m = 16'h0001;
        exp_b = model_write(a, 2);
        c0 = ceb_cnt;
        send_aw(8'h31, a, 4'd2);
        send_w_b(2, br, bi, bl);
        checks++;
        if (br !== 2'b10 || br !== exp_b || ceb_cnt - c0 != 3) begin
            errors++; $display("FAIL early_wlast: bresp=%0d writes=%0d, required 2 3", br, ceb_cnt - c0);
        end
        do_read(8'h32, a, 4'd2, 2);
        checks++;
        if (rq_data.size() != 3 || rq_data[0] !== model_read(a, 0) || rq_data[1] !== model_read(a, 1) ||
            rq_data[2] !== model_read(a, 2)) begin
            errors++; $display("FAIL early_wlast_readback: got %0d beats, required 3 matching %h %h %h",
                               rq_data.size(), model_read(a, 0), model_read(a, 1), model_read(a, 2));
        end
    endtask

    task automatic test_reset_mid_read();
        int k = 0;
        int resp_seen = 0;
        int c0;
        @(negedge clk);
        ARID = 8'h41; ARADDR = 32'h80; ARLEN = 4'd3; ARVALID = 1'b1; RREADY = 1'b0;
        @(posedge clk); #1 ARVALID = 1'b0;
        while (!RVALID && k < 10) begin @(negedge clk); k++; end
        checks++;
        if (RVALID !== 1'b1) begin
            errors++; $display("FAIL rst_mid_rvalid: RVALID=%0b, required 1 before reset", RVALID);
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
            errors++; $display("FAIL rst_mid_idle: RVALID=%0b ARREADY=%0b, required 0 1", RVALID, ARREADY);
        end
        c0 = ceb_cnt;
        RREADY = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (RVALID || BVALID) resp_seen++;
        end
        RREADY = 1'b0;
        checks++;
        if (resp_seen != 0 || ceb_cnt != c0) begin
            errors++; $display("FAIL rst_mid_quiet: responses=%0d sram_accesses=%0d, required 0 0", resp_seen, ceb_cnt - c0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            int w, len, c0, mode, bl;
            logic [31:0] a;
            logic [7:0] id, bi;
            logic [1:0] br, exp_b;
            w = $urandom_range(0, 1) ? $urandom_range(0, 120) : WORDS - 16 + $urandom_range(0, 15);
            a = (32'(w) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) a = a | (32'h1 << $urandom_range(16, 31));
            len = $urandom_range(0, 15);
            id = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
                wlast_m = 16'h1 << len;
                if ($urandom_range(0, 4) == 0) wlast_m = 16'($urandom);
                exp_b = model_write(a, len);
                c0 = ceb_cnt;
                send_aw(id, a, 4'(len));
                send_w_b(len, br, bi, bl);
                checks++;
                if (br !== exp_b || bi !== id || bl != 2 || ceb_cnt - c0 != (addr_err(a) ? 0 : len + 1)) begin
                    errors++; $display("FAIL rand_wr %0d: bresp=%0d bid=%h lat=%0d writes=%0d, required %0d %h 2 %0d",
                                       n, br, bi, bl, ceb_cnt - c0, exp_b, id, addr_err(a) ? 0 : len + 1);
                end
            end else begin
                mode = $urandom_range(0, 2);
                do_read(id, a, 4'(len), mode);
                checks++;
                if (rq_data.size() != len + 1 || stall_bad != 0) begin
                    errors++; $display("FAIL rand_rd %0d: beats=%0d stall_changes=%0d, required %0d 0", n, rq_data.size(), stall_bad, len + 1);
                end else begin
                    for (int i = 0; i <= len; i++) begin
                        logic [1:0] er;
                        er = addr_err(a) ? 2'b10 : 2'b00;
                        checks++;
                        if (rq_data[i] !== model_read(a, i) || rq_resp[i] !== er || rq_last[i] !== (i == len) ||
                            rq_id[i] !== id || (mode == 0 && rq_lat[i] != 2 * (i + 1))) begin
                            errors++; $display("FAIL rand_rd %0d beat %0d: data=%h resp=%0d last=%0b id=%h lat=%0d, required %h %0d %0b %h %0d",
                                               n, i, rq_data[i], rq_resp[i], rq_last[i], rq_id[i], rq_lat[i],
                                               model_read(a, i), er, i == len, id, 2 * (i + 1));
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_final_memory();
        int bad = 0;
        for (int w = 0; w < 'h90; w++) if (mem[w] !== ref_mem[w]) bad++;
        for (int w = WORDS - 16; w < WORDS; w++) if (mem[w] !== ref_mem[w]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL final_memory: %0d words differ from reference, required 0", bad);
        end
    endtask

    initial begin
        rst = 1'b1;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_dat = '0;
        test_reset();
        test_single_read();
        test_strobed_write();
        test_burst_stall();
        test_wrap_error();
        test_priority();
        test_early_wlast();
        test_reset_mid_read();
        test_random();
        test_final_memory();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
